// File: rtl/aim_pkg.sv
// Shared types and default sizing for the AIM layer scheduler.
package aim_pkg;

    localparam int unsigned NUM_NEURONS_DEF = 8;
    localparam int unsigned ACC_W_DEF       = 13;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        EMIT,
        DONE
    } sched_state_t;

endpackage

// File: rtl/aim_result_post.sv
// Result post-processing applied at capture: ReLU clamp when AIM_RELU_EN is
// defined, otherwise a plain pass-through of the signed engine result.
module aim_result_post
    import aim_pkg::*;
#(
    parameter int unsigned ACC_W = ACC_W_DEF
) (
    input  logic signed [ACC_W-1:0] data_i,
    output logic signed [ACC_W-1:0] data_o
);

    always_comb begin
`ifdef AIM_RELU_EN
        data_o = data_i[ACC_W-1] ? '0 : data_i;
`else
        data_o = data_i;
`endif
    end

endmodule

// File: rtl/aim_layer_sched.sv
// Sequences one layer of neurons through a shared AIM dot-product engine and
// streams tagged results. Optional ReLU on results via AIM_RELU_EN.
module aim_layer_sched
    import aim_pkg::*;
#(
    parameter int unsigned NUM_NEURONS = NUM_NEURONS_DEF,
    parameter int unsigned IDX_W       = $clog2(NUM_NEURONS),
    parameter int unsigned ACC_W       = ACC_W_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic [IDX_W:0]          layer_size,
    input  logic                    abort,
    output logic                    busy,
    output logic                    layer_done,
    output logic                    act_load,
    output logic                    eng_start,
    output logic [IDX_W-1:0]        eng_idx,
    input  logic                    eng_done,
    input  logic signed [ACC_W-1:0] eng_result,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic signed [ACC_W-1:0] res_data,
    output logic [IDX_W-1:0]        res_idx
);

    localparam logic [IDX_W:0] MAX_SIZE = (IDX_W+1)'(NUM_NEURONS);

    sched_state_t             state_q;
    logic [IDX_W:0]           size_q;
    logic [IDX_W-1:0]         idx_q;
    logic                     busy_q;
    logic                     layer_done_q;
    logic                     act_load_q;
    logic                     eng_start_q;
    logic                     res_valid_q;
    logic signed [ACC_W-1:0]  res_data_q;
    logic [IDX_W-1:0]         res_idx_q;

    logic [IDX_W:0]           size_d;
    logic [IDX_W:0]           size_m1;
    logic                     is_last;
    logic signed [ACC_W-1:0]  post_data;

    aim_result_post #(
        .ACC_W (ACC_W)
    ) u_post (
        .data_i (eng_result),
        .data_o (post_data)
    );

    always_comb begin
        size_d  = (layer_size > MAX_SIZE) ? MAX_SIZE : layer_size;
        size_m1 = size_q - (IDX_W+1)'(1);
        is_last = ({1'b0, idx_q} == size_m1);
    end

    // Outputs are registered alongside the state, so each one is set for the
    // state being entered rather than decoded from the current state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            size_q       <= '0;
            idx_q        <= '0;
            busy_q       <= 1'b0;
            layer_done_q <= 1'b0;
            act_load_q   <= 1'b0;
            eng_start_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            res_data_q   <= '0;
            res_idx_q    <= '0;
        end else begin
            layer_done_q <= 1'b0;
            act_load_q   <= 1'b0;
            eng_start_q  <= 1'b0;
            if (abort) begin
                state_q     <= IDLE;
                busy_q      <= 1'b0;
                res_valid_q <= 1'b0;
                idx_q       <= '0;
            end else begin
                case (state_q)
                    IDLE: if (start) begin
                        state_q    <= LOAD;
                        size_q     <= size_d;
                        idx_q      <= '0;
                        busy_q     <= 1'b1;
                        act_load_q <= 1'b1;
                    end
                    LOAD: if (size_q == '0) begin
                        state_q      <= DONE;
                        layer_done_q <= 1'b1;
                    end else begin
                        state_q     <= ISSUE;
                        eng_start_q <= 1'b1;
                    end
                    ISSUE: state_q <= WAIT;
                    WAIT: if (eng_done) begin
                        state_q     <= EMIT;
                        res_valid_q <= 1'b1;
                        res_data_q  <= post_data;
                        res_idx_q   <= idx_q;
                    end
                    EMIT: if (res_ready) begin
                        res_valid_q <= 1'b0;
                        if (is_last) begin
                            state_q      <= DONE;
                            layer_done_q <= 1'b1;
                        end else begin
                            state_q     <= ISSUE;
                            idx_q       <= idx_q + IDX_W'(1);
                            eng_start_q <= 1'b1;
                        end
                    end
                    DONE: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign busy       = busy_q;
    assign layer_done = layer_done_q;
    assign act_load   = act_load_q;
    assign eng_start  = eng_start_q;
    assign eng_idx    = idx_q;
    assign res_valid  = res_valid_q;
    assign res_data   = res_data_q;
    assign res_idx    = res_idx_q;

endmodule
